barrel_shift_arbiter: RTL and testbench
=======================================

Name: barrel_shift_arbiter

Overview:
- Shares one combinational barrel shifter between NUM_REQ requesters.
- Each requester has its own valid/ready request channel. Requests are granted round-robin.
- The granted operands are driven to the shared shifter, and its result is captured in a single response register tagged with the requester ID.
- Sits between the execution-side requesters and the single shifter instance; one shift is accepted per cycle while the response side is not stalled.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 4.
- NUM_REQ, 4, number of requesters; 2..16.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).
- IDW, $clog2(NUM_REQ), response ID width (derived, not overridden).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- req_valid_i  input  NUM_REQ  per-requester request valid
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero
- req_data_i  input  NUM_REQ*WIDTH  operand; requester k in bits [k*WIDTH +: WIDTH]
- req_shamt_i  input  NUM_REQ*SHW  shift amount, packed as req_data_i
- req_dir_i  input  NUM_REQ  0 = left, 1 = right
- req_arith_i  input  NUM_REQ  0 = logical, 1 = arithmetic
- shf_data_o  output  WIDTH  operand to shared shifter
- shf_shamt_o  output  SHW  shift amount to shared shifter
- shf_dir_o  output  1  direction to shared shifter
- shf_arith_o  output  1  mode to shared shifter
- shf_result_i  input  WIDTH  combinational result from shared shifter
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response consumer ready
- resp_data_o  output  WIDTH  registered shift result
- resp_id_o  output  IDW  index of the requester that issued the result

Behaviour:
- Clock and reset
  - One clock (clk_i). Reset is synchronous and active-high (rst_i).
  - While rst_i = 1, req_ready_o = 0 and no grant is issued.
- Reset values: resp_valid_o = 0, resp_data_o = 0, resp_id_o = 0, round-robin pointer = 0 (requester 0 highest priority).
- Slot-free condition
  - slot_free = !resp_valid_o || resp_ready_i.
  - The response register holds one entry; the slot_free path through resp_ready_i is combinational.
- Arbitration (combinational)
  - When slot_free, grant the first k with req_valid_i[k] = 1, searching from the pointer upward with wrap-around modulo NUM_REQ.
  - req_ready_o[k] = 1 only for the granted k, else 0.
  - No grant when slot_free = 0 or no request is valid.
- Shifter drive
  - shf_* outputs carry the granted requester's fields.
  - With no grant they are all-zero: data 0, shamt 0, dir 0, arith 0.
  - The block performs no shifting itself; shf_result_i is sampled as-is.
- Accept (req_valid_i[k] && req_ready_o[k] at a rising edge)
  - resp_data_o <= shf_result_i, resp_id_o <= k, resp_valid_o <= 1.
  - Pointer <= (k + 1) mod NUM_REQ.
  - Latency: the response is visible on the cycle after accept.
- Drain without new accept: resp_valid_o && resp_ready_i with no grant -> resp_valid_o <= 0. resp_data_o and resp_id_o hold their last values.
- Simultaneous drain and accept in the same cycle: the register reloads with the new result, resp_valid_o stays 1, and there is no bubble. Sustained throughput is 1 per cycle.
- Stall: resp_valid_o && !resp_ready_i -> resp_data_o and resp_id_o are held stable, req_ready_o = 0, and the pointer is unchanged.
- Pointer
  - Advances only on accept; no advance on idle or stall cycles.
  - A lone continuous requester is granted every cycle.
- Requester obligations (checked by assertions in the bench, not by RTL): once req_valid_i[k] is raised, it and k's operands stay stable until accepted.
- Fairness: with all NUM_REQ requesters continuously valid and resp_ready_i = 1, grants rotate 0, 1, …, NUM_REQ-1, 0 with no requester waiting more than NUM_REQ-1 accepts.
- Reset mid-operation: a pending response is discarded (resp_valid_o = 0 on the cycle after rst_i is sampled high) and the pointer returns to 0.

Test Plan:
- WIDTH=8, NUM_REQ=4, bench uses an ideal shifter model on shf_*.
- Single request: req 2 valid, data 0x81, shamt 1, dir 0, arith 0, resp_ready_i = 1 -> req_ready_o = 0b0100 on the accept cycle; next cycle resp_valid_o = 1, resp_data_o = 0x02, resp_id_o = 2.
- Arithmetic right: req 0 data 0x90, shamt 3, dir 1, arith 1 -> resp_data_o = 0xF2, resp_id_o = 0. Same request with arith 0 -> 0x12.
- Round-robin: all 4 valid continuously, resp_ready_i = 1 for 8 cycles -> resp_id_o sequence 0,1,2,3,0,1,2,3 on consecutive cycles, no bubbles.
- Backpressure:
  - Request accepted, then resp_ready_i = 0 for 5 cycles -> resp_data_o/resp_id_o stable, req_ready_o = 0 throughout.
  - Raise resp_ready_i with req 1 valid -> drain and accept in the same cycle; resp_valid_o stays 1 with resp_id_o = 1 next cycle.
- Pointer hold: grant req 3 (pointer -> 0), idle 3 cycles, then req 1 and req 3 valid together -> req 1 granted first, then req 3.
- Reset mid-operation: resp_valid_o = 1 with resp_id_o = 2, assert rst_i for 1 cycle -> resp_valid_o = 0, resp_data_o = 0, resp_id_o = 0; after release, reqs 0 and 2 both valid -> req 0 granted first.

Source files
------------

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter that lends one shared combinational barrel shifter to
// NUM_REQ requesters and returns each result in a single ID-tagged register.
module barrel_shift_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int SHW     = $clog2(WIDTH),
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*SHW-1:0]   req_shamt_i,
  input  logic [NUM_REQ-1:0]       req_dir_i,
  input  logic [NUM_REQ-1:0]       req_arith_i,
  output logic [WIDTH-1:0]         shf_data_o,
  output logic [SHW-1:0]           shf_shamt_o,
  output logic                     shf_dir_o,
  output logic                     shf_arith_o,
  input  logic [WIDTH-1:0]         shf_result_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [WIDTH-1:0]         resp_data_o,
  output logic [IDW-1:0]           resp_id_o
);

  logic           slot_free;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;

  // The response slot frees up in the same cycle the consumer drains it,
  // which is what allows back-to-back accepts.
  assign slot_free = !resp_valid_o || resp_ready_i;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (slot_free && !rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = IDW'((int'(ptr) + i) % NUM_REQ);
        if (!grant_vld && req_valid_i[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    shf_data_o  = '0;
    shf_shamt_o = '0;
    shf_dir_o   = 1'b0;
    shf_arith_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_vld && grant_idx == IDW'(k)) begin
        req_ready_o[k] = 1'b1;
        shf_data_o     = req_data_i[k*WIDTH +: WIDTH];
        shf_shamt_o    = req_shamt_i[k*SHW +: SHW];
        shf_dir_o      = req_dir_i[k];
        shf_arith_o    = req_arith_i[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_id_o    <= '0;
      ptr          <= '0;
    end else if (grant_vld) begin
      resp_valid_o <= 1'b1;
      resp_data_o  <= shf_result_i;
      resp_id_o    <= grant_idx;
      ptr          <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (resp_ready_i) begin
      // Drain only: data and ID keep their last values.
      resp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_barrel_shift_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int SHW     = $clog2(WIDTH);
  localparam int IDW     = $clog2(NUM_REQ);

  typedef struct {
    bit       v;
    bit [7:0] data;
    int       shamt;
    bit       dir;
    bit       arith;
  } req_t;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ*SHW-1:0]   req_shamt_i;
  logic [NUM_REQ-1:0]       req_dir_i;
  logic [NUM_REQ-1:0]       req_arith_i;
  logic [WIDTH-1:0]         shf_data_o;
  logic [SHW-1:0]           shf_shamt_o;
  logic                     shf_dir_o;
  logic                     shf_arith_o;
  logic [WIDTH-1:0]         shf_result_i;
  logic                     resp_valid_o;
  logic                     resp_ready_i;
  logic [WIDTH-1:0]         resp_data_o;
  logic [IDW-1:0]           resp_id_o;

  req_t pend [NUM_REQ];
  bit   auto_reissue;

  // Reference model state.
  int       m_ptr;
  bit       m_valid;
  bit [7:0] m_data;
  int       m_id;
  int       exp_gnt;
  int       n_checks;
  int       n_fail;

  barrel_shift_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_shamt_i  (req_shamt_i),
    .req_dir_i    (req_dir_i),
    .req_arith_i  (req_arith_i),
    .shf_data_o   (shf_data_o),
    .shf_shamt_o  (shf_shamt_o),
    .shf_dir_o    (shf_dir_o),
    .shf_arith_o  (shf_arith_o),
    .shf_result_i (shf_result_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_id_o    (resp_id_o)
  );

  always #5 clk_i = ~clk_i;

  // Shift computed with integer arithmetic: multiply/divide by 2**sh, and for
  // arithmetic right shifts fill the vacated top bits with ones when negative.
  function automatic bit [7:0] shift_ref(bit [7:0] d, int sh, bit dir, bit arith);
    int p;
    int r;
    p = 1 << sh;
    if (!dir) r = (int'(d) * p) % 256;
    else begin
      r = int'(d) / p;
      if (arith && d[7]) r = r + (256 - 256 / p);
    end
    return 8'(r);
  endfunction

  // Ideal external shifter attached to the shf_* port.
  always_comb shf_result_i = shift_ref(shf_data_o, int'(shf_shamt_o), shf_dir_o, shf_arith_o);

  always_comb begin
    req_valid_i = '0;
    req_data_i  = '0;
    req_shamt_i = '0;
    req_dir_i   = '0;
    req_arith_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid_i[k]              = pend[k].v;
      req_data_i[k*WIDTH +: WIDTH] = pend[k].data;
      req_shamt_i[k*SHW +: SHW]   = SHW'(pend[k].shamt);
      req_dir_i[k]                = pend[k].dir;
      req_arith_i[k]              = pend[k].arith;
    end
  end

  // Requester obligation: once raised, a request and its operands hold until accepted.
  logic [NUM_REQ-1:0]       held_q = '0;
  logic [NUM_REQ*WIDTH-1:0] data_q;
  logic [NUM_REQ*SHW-1:0]   shamt_q;
  logic [NUM_REQ-1:0]       dir_q;
  logic [NUM_REQ-1:0]       arith_q;
  always @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (held_q[k]) begin
        assert (req_valid_i[k] && req_dir_i[k] == dir_q[k] && req_arith_i[k] == arith_q[k]
                && req_data_i[k*WIDTH +: WIDTH] == data_q[k*WIDTH +: WIDTH]
                && req_shamt_i[k*SHW +: SHW] == shamt_q[k*SHW +: SHW])
          else $error("requester %0d changed a pending request", k);
      end
    end
    held_q  <= req_valid_i & ~req_ready_o;
    data_q  <= req_data_i;
    shamt_q <= req_shamt_i;
    dir_q   <= req_dir_i;
    arith_q <= req_arith_i;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(int k, bit [7:0] data, int shamt, bit dir, bit arith);
    pend[k].v     = 1'b1;
    pend[k].data  = data;
    pend[k].shamt = shamt;
    pend[k].dir   = dir;
    pend[k].arith = arith;
  endtask

  task automatic set_rand_req(int k);
    set_req(k, 8'($urandom), int'($urandom_range(0, WIDTH - 1)),
            1'($urandom), 1'($urandom));
  endtask

  // One clock cycle: inputs are already applied. Combinational outputs are
  // compared at the falling edge, registered outputs 1 time unit after the
  // rising edge, then the model advances and new inputs may be driven.
  task automatic cycle();
    logic [NUM_REQ-1:0] e_ready;
    bit   [7:0]         e_data;
    int                 e_shamt;
    bit                 e_dir;
    bit                 e_arith;
    exp_gnt = -1;
    if (!rst_i && (!m_valid || resp_ready_i)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_gnt < 0 && pend[(m_ptr + i) % NUM_REQ].v) exp_gnt = (m_ptr + i) % NUM_REQ;
      end
    end
    e_ready = '0;
    e_data  = '0;
    e_shamt = 0;
    e_dir   = 1'b0;
    e_arith = 1'b0;
    if (exp_gnt >= 0) begin
      e_ready[exp_gnt] = 1'b1;
      e_data  = pend[exp_gnt].data;
      e_shamt = pend[exp_gnt].shamt;
      e_dir   = pend[exp_gnt].dir;
      e_arith = pend[exp_gnt].arith;
    end
    @(negedge clk_i);
    check("req_ready", 32'(req_ready_o), 32'(e_ready));
    check("shf_data",  32'(shf_data_o),  32'(e_data));
    check("shf_shamt", 32'(shf_shamt_o), 32'(e_shamt));
    check("shf_dir",   32'(shf_dir_o),   32'(e_dir));
    check("shf_arith", 32'(shf_arith_o), 32'(e_arith));
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
    end else if (exp_gnt >= 0) begin
      m_valid = 1'b1;
      m_data  = shift_ref(pend[exp_gnt].data, pend[exp_gnt].shamt,
                          pend[exp_gnt].dir, pend[exp_gnt].arith);
      m_id    = exp_gnt;
      m_ptr   = (exp_gnt + 1) % NUM_REQ;
      if (auto_reissue) set_rand_req(exp_gnt);
      else pend[exp_gnt].v = 1'b0;
    end else if (resp_ready_i) begin
      m_valid = 1'b0;
    end
    check("resp_valid", 32'(resp_valid_o), 32'(m_valid));
    check("resp_data",  32'(resp_data_o),  32'(m_data));
    check("resp_id",    32'(resp_id_o),    32'(m_id));
  endtask

  task automatic drain_all();
    bit busy;
    resp_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      busy = m_valid;
      for (int k = 0; k < NUM_REQ; k++) busy |= pend[k].v;
      if (busy) cycle();
    end
    check("drained", 32'(resp_valid_o | (|req_valid_i)), 32'(0));
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    auto_reissue = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0;
    for (int k = 0; k < NUM_REQ; k++) pend[k] = '{1'b0, 8'h00, 0, 1'b0, 1'b0};
    rst_i        = 1'b1;
    resp_ready_i = 1'b1;
    cycle();
    cycle();
    check("reset_valid", 32'(resp_valid_o), 32'(0));
    check("reset_id",    32'(resp_id_o),    32'(0));
    rst_i = 1'b0;

    // Single request and shift-mode results.
    set_req(2, 8'h81, 1, 1'b0, 1'b0);
    cycle();
    check("single_data", 32'(resp_data_o), 32'h02);
    check("single_id",   32'(resp_id_o),   32'd2);
    set_req(0, 8'h90, 3, 1'b1, 1'b1);
    cycle();
    check("sra_data", 32'(resp_data_o), 32'hF2);
    check("sra_id",   32'(resp_id_o),   32'd0);
    set_req(0, 8'h90, 3, 1'b1, 1'b0);
    cycle();
    check("srl_data", 32'(resp_data_o), 32'h12);
    drain_all();

    // Bring the pointer to 0, then all requesters continuously valid.
    set_req(3, 8'h01, 0, 1'b0, 1'b0);
    cycle();
    auto_reissue = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) set_rand_req(k);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_valid", 32'(resp_valid_o), 32'd1);
      check("rr_id",    32'(resp_id_o),    32'(i % NUM_REQ));
    end
    auto_reissue = 1'b0;
    drain_all();

    // Backpressure: stall for 5 cycles, then drain and accept together.
    set_req(2, 8'h5A, 2, 1'b0, 1'b0);
    cycle();
    resp_ready_i = 1'b0;
    set_req(1, 8'hC3, 4, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_ready", 32'(req_ready_o), 32'd0);
      check("stall_id",    32'(resp_id_o),   32'd2);
      check("stall_data",  32'(resp_data_o), 32'h68);
    end
    resp_ready_i = 1'b1;
    cycle();
    check("reload_valid", 32'(resp_valid_o), 32'd1);
    check("reload_id",    32'(resp_id_o),    32'd1);
    drain_all();

    // Pointer holds across idle cycles.
    set_req(3, 8'h0F, 1, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    set_req(1, 8'h11, 0, 1'b0, 1'b0);
    set_req(3, 8'h33, 0, 1'b0, 1'b0);
    cycle();
    check("hold_first",  32'(resp_id_o), 32'd1);
    cycle();
    check("hold_second", 32'(resp_id_o), 32'd3);
    drain_all();

    // Reset in the middle of a pending response.
    resp_ready_i = 1'b0;
    set_req(2, 8'hAA, 1, 1'b1, 1'b0);
    cycle();
    check("prerst_id", 32'(resp_id_o), 32'd2);
    set_req(0, 8'h44, 1, 1'b0, 1'b0);
    rst_i = 1'b1;
    cycle();
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_data",  32'(resp_data_o),  32'd0);
    check("rst_id",    32'(resp_id_o),    32'd0);
    rst_i        = 1'b0;
    resp_ready_i = 1'b1;
    set_req(2, 8'hAA, 1, 1'b1, 1'b0);
    cycle();
    check("postrst_first",  32'(resp_id_o), 32'd0);
    cycle();
    check("postrst_second", 32'(resp_id_o), 32'd2);
    drain_all();

    // Randomized traffic with random backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      resp_ready_i = ($urandom_range(0, 3) != 0);
      rst_i        = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pend[k].v && $urandom_range(0, 4) < 2) set_rand_req(k);
      end
      cycle();
    end
    rst_i = 1'b0;
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
